// File: rtl/scan_fifo_writer.sv
// scan_fifo_writer: write-side controller for the scan line FIFO.
// Packs accepted byte pairs into 16-bit words, counts words per scan line,
// and stalls upstream with watermark hysteresis on wrusedw.
// Optional feature: SCAN_WR_PAD_EN pads a short line out to LINE_LEN words
// with zeros instead of discarding it.
module scan_fifo_writer #(
  parameter int unsigned WATER_HIGH = 120,
  parameter int unsigned WATER_LOW  = 64,
  parameter int unsigned LINE_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        din_sol,
  output logic        din_ready,
  output logic        wrreq,
  output logic [15:0] wrdata,
  input  logic [6:0]  wrusedw,
  input  logic        wrfull,
  output logic        line_done,
  output logic        short_err,
  output logic        ovf_err,
  input  logic        err_clr
);

`ifdef SCAN_WR_PAD_EN
  typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1, PAD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic        have_pend_q, have_pend_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [6:0]  cnt_inc;
  logic        last_word;
  logic        wrreq_d;
  logic [15:0] wrdata_d;
  logic        line_done_d;
  logic        short_set;
`ifdef SCAN_WR_PAD_EN
  logic [7:0]  hold_q, hold_d;
`endif

  assign last_word = (cnt_q == 7'(LINE_LEN - 1));
  assign cnt_inc   = last_word ? '0 : cnt_q + 7'd1;

  // Next-state, packing and write decisions.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    have_pend_d = have_pend_q;
    cnt_d       = cnt_q;
    wrreq_d     = 1'b0;
    wrdata_d    = wrdata;
    line_done_d = 1'b0;
    short_set   = 1'b0;
    din_ready   = 1'b0;
`ifdef SCAN_WR_PAD_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      FILL: begin
        din_ready = !wrfull && !rst;
        if (wrusedw >= 7'(WATER_HIGH)) state_d = HOLD;
        if (din_valid && din_ready) begin
          if (din_sol && (cnt_q != '0 || have_pend_q)) begin
            short_set = 1'b1;
`ifdef SCAN_WR_PAD_EN
            // Pad takes priority over a simultaneous watermark stall.
            hold_d  = din;
            state_d = PAD;
`else
            pend_d      = din;
            have_pend_d = 1'b1;
            cnt_d       = '0;
`endif
          end else if (!have_pend_q) begin
            pend_d      = din;
            have_pend_d = 1'b1;
          end else begin
            wrreq_d     = 1'b1;
            wrdata_d    = {pend_q, din};
            have_pend_d = 1'b0;
            cnt_d       = cnt_inc;
            line_done_d = last_word;
          end
        end
      end
      HOLD: begin
        if (wrusedw <= 7'(WATER_LOW)) state_d = FILL;
      end
`ifdef SCAN_WR_PAD_EN
      PAD: begin
        if (!wrfull) begin
          wrreq_d     = 1'b1;
          wrdata_d    = have_pend_q ? {pend_q, 8'h00} : '0;
          have_pend_d = 1'b0;
          cnt_d       = cnt_inc;
          if (last_word) begin
            line_done_d = 1'b1;
            state_d     = FILL;
            pend_d      = hold_q;
            have_pend_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Datapath, write port and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      have_pend_q <= 1'b0;
      cnt_q       <= '0;
      wrreq       <= 1'b0;
      wrdata      <= '0;
      line_done   <= 1'b0;
      short_err   <= 1'b0;
      ovf_err     <= 1'b0;
`ifdef SCAN_WR_PAD_EN
      hold_q      <= '0;
`endif
    end else begin
      pend_q      <= pend_d;
      have_pend_q <= have_pend_d;
      cnt_q       <= cnt_d;
      wrreq       <= wrreq_d;
      wrdata      <= wrdata_d;
      line_done   <= line_done_d;
      short_err   <= short_set | (short_err & ~err_clr);
      ovf_err     <= (wrreq & wrfull) | (ovf_err & ~err_clr);
`ifdef SCAN_WR_PAD_EN
      hold_q      <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_scan_fifo_writer.sv
// Scoreboard bench for scan_fifo_writer: a byte-level model pushes expected
// words as bytes are accepted; a monitor pops them when wrreq is seen.
module tb_scan_fifo_writer;
  localparam int unsigned L = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_sol = 1'b0;
  logic        din_ready;
  logic        wrreq;
  logic [15:0] wrdata;
  logic [6:0]  wrusedw = '0;
  logic        wrfull = 1'b0;
  logic        line_done;
  logic        short_err;
  logic        ovf_err;
  logic        err_clr = 1'b0;

  scan_fifo_writer #(.WATER_HIGH(120), .WATER_LOW(64), .LINE_LEN(L)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sol(din_sol),
    .din_ready(din_ready), .wrreq(wrreq), .wrdata(wrdata), .wrusedw(wrusedw),
    .wrfull(wrfull), .line_done(line_done), .short_err(short_err),
    .ovf_err(ovf_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] d; logic ld; int st;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] m_pend = '0;
  logic       m_have = 1'b0;
  int         m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic ld, input int st);
    exp_t e;
    e.d = d; e.ld = ld; e.st = st;
    sb.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic sol, input int c);
    logic first;
    if (sol && (m_cnt != 0 || m_have)) begin
`ifdef SCAN_WR_PAD_EN
      first = m_have;
      do begin
        push(first ? {m_pend, 8'h00} : 16'h0000, m_cnt == L - 1, -1);
        first = 1'b0;
        m_cnt = (m_cnt + 1) % L;
      end while (m_cnt != 0);
`else
      first = 1'b0;
`endif
      m_pend = b; m_have = 1'b1; m_cnt = 0;
    end else if (!m_have) begin
      m_pend = b; m_have = 1'b1;
    end else begin
      push({m_pend, b}, m_cnt == L - 1, c);
      m_have = 1'b0;
      m_cnt = (m_cnt + 1) % L;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sol);
    int  n;
    logic acc;
    n = 0; acc = 1'b0;
    din = b; din_sol = sol; din_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk); acc = din_ready;
      @(posedge clk); #1; n++;
    end
    din_valid = 1'b0; din_sol = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    else model_byte(b, sol, cyc);
  endtask

  task automatic send_bytes(input logic [7:0] base, input int n, input logic sol_first);
    for (int i = 0; i < n; i++) send_byte(8'(base + 8'(i)), sol_first && i == 0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wrreq) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("wrdata", wrdata, mon_e.d);
          chk("line_done", line_done, mon_e.ld);
          if (mon_e.st >= 0) chk("latency", cyc, mon_e.st);
        end
      end else begin
        chk("ld_without_wr", line_done, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(2);
    chk("rst_wrreq", wrreq, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_short_err", short_err, 0);
    chk("rst_ovf_err", ovf_err, 0);
    chk("rst_din_ready", din_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", din_ready, 1);

    // Full line 0x01..0x80
    send_bytes(8'h01, 128, 1'b1);

    // Watermark hysteresis mid-line; pending byte survives HOLD
    send_bytes(8'h10, 11, 1'b1);
    wrusedw = 7'd120;
    tick(1);
    chk("hold_enter_rdy", din_ready, 0);
    wrusedw = 7'd90;
    tick(5);
    chk("hold_mid_rdy", din_ready, 0);
    wrusedw = 7'd64;
    tick(1);
    chk("hold_exit_rdy", din_ready, 1);
    wrusedw = 7'd0;
    send_bytes(8'h1B, 117, 1'b0);

    // Short line
    send_bytes(8'hA0, 5, 1'b1);
    send_byte(8'hB0, 1'b1);
    chk("short_err_set", short_err, 1);
`ifdef SCAN_WR_PAD_EN
    chk("pad_rdy_low", din_ready, 0);
    tick(30);
    chk("pad_rdy_low_mid", din_ready, 0);
`endif
    send_bytes(8'hB1, 127, 1'b0);
    chk("short_err_sticky", short_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("short_err_clr", short_err, 0);

    // Overflow: wrfull during a registered wrreq
    send_byte(8'hE0, 1'b1);
    send_byte(8'hE1, 1'b0);
    wrfull = 1'b1;
    #1;
    chk("rdy_full", din_ready, 0);
    @(posedge clk); #1;
    wrfull = 1'b0;
    chk("ovf_set", ovf_err, 1);
    tick(3);
    chk("ovf_sticky", ovf_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovf_clr", ovf_err, 0);
    send_bytes(8'h40, 126, 1'b0);

    // Reset mid-pair (or mid-PAD with padding enabled)
    send_bytes(8'hC0, 3, 1'b1);
    send_byte(8'hD0, 1'b1);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mrst_wrreq", wrreq, 0);
    chk("mrst_wrdata", wrdata, 0);
    chk("mrst_line_done", line_done, 0);
    chk("mrst_short_err", short_err, 0);
    chk("mrst_ovf_err", ovf_err, 0);
    chk("mrst_din_ready", din_ready, 0);
    sb.delete();
    m_have = 1'b0; m_cnt = 0; m_pend = '0;
    rst = 1'b0;
    #1;

    // Clean line after reset
    send_bytes(8'h61, 128, 1'b1);
    tick(5);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
